// File: rtl/grey_counter_n.sv
// Parameterised Gray-code counter: binary state register, registered Gray and binary views,
// terminal-count pulse, load and wrap/saturate. Define GREY_COUNTER_DIR_EN to add the dir port.
module grey_counter_n #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned WRAP  = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
`ifdef GREY_COUNTER_DIR_EN
   input  logic             dir,
`endif
   output logic [WIDTH-1:0] count,
   output logic [WIDTH-1:0] bin,
   output logic             tc
);

   localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};

   logic [WIDTH-1:0] bin_q, bin_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic             tc_q, tc_d;
   logic [WIDTH-1:0] load_bin_c;
   logic [WIDTH-1:0] end_val_c;
   logic             up_c;
   logic             acc_c;

   // Direction select; the up-only build ties it high.
   always_comb begin
`ifdef GREY_COUNTER_DIR_EN
      up_c = dir;
`else
      up_c = 1'b1;
`endif
      end_val_c = up_c ? ALL_ONES : ZERO;
   end

   // Gray-to-binary of the load value: each bit is the XOR of all higher-or-equal Gray bits.
   always_comb begin
      load_bin_c = ZERO;
      acc_c      = 1'b0;
      for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
         acc_c         = acc_c ^ load_val[i];
         load_bin_c[i] = acc_c;
      end
   end

   // Next-state: load beats enable beats hold; tc marks every step taken from the end value.
   always_comb begin
      bin_d = bin_q;
      tc_d  = 1'b0;
      if (load) begin
         bin_d = load_bin_c;
      end else if (en) begin
         if (bin_q == end_val_c) begin
            tc_d = 1'b1;
            if (WRAP != 0) begin
               bin_d = up_c ? ZERO : ALL_ONES;
            end
         end else begin
            bin_d = up_c ? (bin_q + WIDTH'(1)) : (bin_q - WIDTH'(1));
         end
      end
      count_d = bin_d ^ (bin_d >> 1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bin_q   <= ZERO;
         count_q <= ZERO;
         tc_q    <= 1'b0;
      end else begin
         bin_q   <= bin_d;
         count_q <= count_d;
         tc_q    <= tc_d;
      end
   end

   assign bin   = bin_q;
   assign count = count_q;
   assign tc    = tc_q;

endmodule

// File: doc/grey_counter_n.md
GREY_COUNTER_N -- requirements
Module: grey_counter_n

Interface
REQ-001 Parameter WIDTH, default 8, counter width in bits; legal range 2..32.
REQ-002 Parameter WRAP, default 1; 1 = wrap at end value, 0 = saturate at end value.
REQ-003 clk  input  1  rising-edge clock; all state changes on posedge clk only.
REQ-004 rst  input  1  synchronous, active-high reset; sampled on posedge clk.
REQ-005 en  input  1  count enable; one step per cycle while high.
REQ-006 load  input  1  synchronous load strobe.
REQ-007 load_val  input  WIDTH  Gray-coded value to load.
REQ-008 dir  input  1  direction, 1 = up, 0 = down; present only with GREY_COUNTER_DIR_EN.
REQ-009 count  output  WIDTH  registered Gray-coded count.
REQ-010 bin  output  WIDTH  registered binary equivalent of count.
REQ-011 tc  output  1  registered terminal-count flag, one-cycle pulse per end event.

Function
REQ-012 Internal state SHALL be a WIDTH-bit binary register; bin SHALL be that register.
REQ-013 count SHALL equal bin ^ (bin >> 1) in every cycle; both update on the same edge, with no cycle skew.
REQ-014 Priority per edge SHALL be: rst > load > en > hold.
REQ-015 load=1: bin <= Gray-to-binary(load_val), i.e. bit i = XOR of load_val[WIDTH-1:i]; en ignored that cycle; tc <= 0.
REQ-016 en=1, load=0, up: bin <= bin + 1 modulo 2^WIDTH when bin != all-ones.
REQ-017 en=1, load=0, down: bin <= bin - 1 when bin != 0.
REQ-018 End value SHALL be all-ones when counting up and 0 when counting down.
REQ-019 Step from end value with WRAP=1: up wraps to 0, down wraps to all-ones; tc <= 1 on that edge.
REQ-020 Step from end value with WRAP=0: bin holds; tc <= 1 on that edge, and on every further enabled edge while held.
REQ-021 tc SHALL be 0 on every edge not covered by REQ-019/REQ-020.
REQ-022 en=0 and load=0: bin holds and tc <= 0.
REQ-023 Successive count values on enabled non-load steps SHALL differ in exactly one bit, including across wrap.
REQ-024 Direction change between consecutive enabled cycles SHALL take effect on the very next edge, with no dead cycle.
REQ-025 Arithmetic SHALL be WIDTH bits unsigned; no internal carry beyond WIDTH SHALL be visible.

Reset
REQ-026 rst=1 at posedge clk: bin <= 0, count <= 0, tc <= 0, overriding load and en.
REQ-027 Reset mid-count SHALL take effect on that edge; counting resumes from 0 on the first edge with rst=0 and en=1.
REQ-028 No output SHALL depend on power-up state after the first reset edge.

Configuration
REQ-029 Macro GREY_COUNTER_DIR_EN defined: dir port exists and selects up/down per REQ-016..REQ-020.
REQ-030 Macro GREY_COUNTER_DIR_EN undefined: dir port absent, counter is up-only, and all other behaviour is unchanged.

Verification
REQ-031 WIDTH=8, WRAP=1, rst then en=1 for 256 cycles -> count 00,01,03,02,06,... and back to 00; tc high only on the FF->00 edge; exactly 1 bit changes per step.
REQ-032 WIDTH=4, WRAP=0, en=1 for 20 cycles -> bin saturates at F (count 1000b); tc high on cycles 16..20; count holds.
REQ-033 WIDTH=8, load=1, load_val=8'hC0, en=1 -> bin=8'h80, count=8'hC0 next cycle; next enabled edge -> bin=8'h81, count=8'hC1.
REQ-034 DIR_EN, WIDTH=4, WRAP=1, bin=0, dir=0, en=1 -> bin=F, count=1000b, tc=1 one cycle; next edge bin=E, tc=0.
REQ-035 Mid-count at bin=8'h37 with rst=1, load=1, en=1 on same edge -> bin=0, count=0, tc=0; next edge with en=1 -> bin=1.
REQ-036 en toggled 1,0,0,1 from bin=5 -> bin 6,6,6,7; tc stays 0; count 0101b,0101b,0101b,0100b.
